ram_port_arbiter: RTL and testbench

- Shares the single SimRAM instance between three requesters: core instruction fetch (read-only), core load/store unit (read/write) and the debug APB path (read/write).
- Sits in TachyonCPU between the requesters and the RAM rd/wr ports. Replaces the direct fetch-to-RAM wiring.
- Grants one access per cycle using fixed priority, with a starvation guard for fetch.
- Tracks outstanding reads so read data returns to the requester that issued them.

---
 rtl/ram_port_arbiter.sv | 115 +++++++++++
 tb/tb_ram_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Three-way arbiter (debug, LSU, fetch) in front of the single-ported SimRAM.
// Fixed priority with a fetch starvation guard; a tag pipeline steers read data back to its issuer.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-3:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  input  logic                  lsu_req,
  input  logic                  lsu_we,
  input  logic [ADDR_WIDTH-3:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  lsu_gnt,
  output logic                  lsu_rvalid,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-3:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-3:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-3:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data
);
  localparam int AW = ADDR_WIDTH - 2;
  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {SRC_NONE, SRC_FETCH, SRC_LSU, SRC_DBG} src_e;

  typedef struct packed {
    logic                  we;
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] wdata;
  } acc_t;

  logic                         hold_off;
  logic [CW-1:0]                starve_cnt;
  logic                         promote;
  logic [RD_LATENCY-1:0][1:0]   tag_pipe;
  src_e                         win;
  src_e                         tag_in;
  src_e                         tail;
  acc_t                         acc;

  assign promote = (STARVE_LIMIT != 0) && (starve_cnt == CW'(STARVE_LIMIT));

  // hold_off keeps grants quiet for the first cycle after reset releases
  always_comb begin
    win = SRC_NONE;
    if (!(rst || hold_off)) begin
      if (dbg_req)                  win = SRC_DBG;
      else if (promote && fetch_req) win = SRC_FETCH;
      else if (lsu_req)             win = SRC_LSU;
      else if (fetch_req)           win = SRC_FETCH;
    end
  end

  always_comb begin
    acc = '{we: 1'b0, addr: fetch_addr, wdata: '0};
    case (win)
      SRC_DBG: acc = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
      SRC_LSU: acc = '{we: lsu_we, addr: lsu_addr, wdata: lsu_wdata};
      default: acc = '{we: 1'b0, addr: fetch_addr, wdata: '0};
    endcase
  end

  always_comb begin
    fetch_gnt   = (win == SRC_FETCH);
    lsu_gnt     = (win == SRC_LSU);
    dbg_gnt     = (win == SRC_DBG);
    ram_rd_en   = (win != SRC_NONE) && !acc.we;
    ram_wr_en   = (win != SRC_NONE) && acc.we;
    // idle/write cycles still present the fetch address for the PC export
    ram_rd_addr = ram_rd_en ? acc.addr : fetch_addr;
    ram_wr_addr = ram_wr_en ? acc.addr : '0;
    ram_wr_data = ram_wr_en ? acc.wdata : '0;
    tag_in      = ram_rd_en ? win : SRC_NONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_off   <= 1'b1;
      starve_cnt <= '0;
      tag_pipe   <= '0;
    end else begin
      hold_off    <= 1'b0;
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (!fetch_req || fetch_gnt)
        starve_cnt <= '0;
      else if (starve_cnt != CW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign tail = src_e'(tag_pipe[RD_LATENCY-1]);

  always_comb begin
    fetch_rvalid = !rst && (tail == SRC_FETCH);
    lsu_rvalid   = !rst && (tail == SRC_LSU);
    dbg_rvalid   = !rst && (tail == SRC_DBG);
    rdata        = ram_rd_data;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: one instance at RD_LATENCY=1, one at RD_LATENCY=2,
// sharing requester inputs; each has its own RAM model returning {16'hC0DE, addr[15:0]}.
module tb_ram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, lsu_req, lsu_we, dbg_req, dbg_we;
  logic [29:0] fetch_addr, lsu_addr, dbg_addr;
  logic [31:0] lsu_wdata, dbg_wdata;

  logic        fetch_gnt, fetch_rvalid, lsu_gnt, lsu_rvalid, dbg_gnt, dbg_rvalid;
  logic        ram_rd_en, ram_wr_en;
  logic [29:0] ram_rd_addr, ram_wr_addr;
  logic [31:0] rdata, ram_rd_data, ram_wr_data;

  logic        fetch_gnt2, fetch_rvalid2, lsu_gnt2, lsu_rvalid2, dbg_gnt2, dbg_rvalid2;
  logic        ram_rd_en2, ram_wr_en2;
  logic [29:0] ram_rd_addr2, ram_wr_addr2;
  logic [31:0] rdata2, ram_rd_data2, ram_wr_data2, rd_q2a;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(1), .STARVE_LIMIT(8)) u_dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata), .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data)
  );

  ram_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(2), .STARVE_LIMIT(8)) u_dut2 (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt2), .fetch_rvalid(fetch_rvalid2),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_gnt(lsu_gnt2), .lsu_rvalid(lsu_rvalid2),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt2), .dbg_rvalid(dbg_rvalid2),
    .rdata(rdata2), .ram_rd_en(ram_rd_en2), .ram_rd_addr(ram_rd_addr2), .ram_rd_data(ram_rd_data2),
    .ram_wr_en(ram_wr_en2), .ram_wr_addr(ram_wr_addr2), .ram_wr_data(ram_wr_data2)
  );

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  always @(posedge clk) begin
    ram_rd_data  <= mem_word(ram_rd_addr);
    rd_q2a       <= mem_word(ram_rd_addr2);
    ram_rd_data2 <= rd_q2a;
  end

  // {fetch_gnt, lsu_gnt, dbg_gnt, fetch_rvalid, lsu_rvalid, dbg_rvalid, rd_en, wr_en}
  function automatic logic [7:0] st1();
    return {fetch_gnt, lsu_gnt, dbg_gnt, fetch_rvalid, lsu_rvalid, dbg_rvalid, ram_rd_en, ram_wr_en};
  endfunction
  function automatic logic [7:0] st2();
    return {fetch_gnt2, lsu_gnt2, dbg_gnt2, fetch_rvalid2, lsu_rvalid2, dbg_rvalid2, ram_rd_en2, ram_wr_en2};
  endfunction

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic clear_reqs();
    fetch_req = 0; lsu_req = 0; dbg_req = 0; lsu_we = 0; dbg_we = 0;
    fetch_addr = '0; lsu_addr = '0; dbg_addr = '0; lsu_wdata = '0; dbg_wdata = '0;
  endtask

  task automatic test_reset();
    clear_reqs();
    rst = 1; fetch_req = 1; fetch_addr = 30'h100;
    next_cycle(); next_cycle();
    @(negedge clk);
    vectors++;
    if (st1() !== 8'h00 || st2() !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_during: got %b/%b want 00000000", st1(), st2());
    end
    next_cycle(); rst = 0;
    @(negedge clk);
    vectors++;
    if (st1() !== 8'h00 || st2() !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_after: got %b/%b want 00000000", st1(), st2());
    end
    next_cycle(); fetch_req = 0;
    next_cycle();
  endtask

  task automatic test_fetch_read();
    fetch_req = 1; fetch_addr = 30'h100;
    @(negedge clk);
    vectors++;
    if (st1() !== 8'b1000_0010 || ram_rd_addr !== 30'h100) begin
      miscompares++;
      $display("FAIL fetch_grant: got st=%b addr=%h want st=10000010 addr=100", st1(), ram_rd_addr);
    end
    next_cycle(); fetch_req = 0;
    @(negedge clk);
    vectors++;
    if (st1() !== 8'b0001_0000 || rdata !== 32'hC0DE0100) begin
      miscompares++;
      $display("FAIL fetch_rvalid: got st=%b rdata=%h want st=00010000 rdata=c0de0100", st1(), rdata);
    end
    vectors++;
    if (ram_rd_addr !== 30'h100 || ram_wr_addr !== 30'h0 || ram_wr_data !== 32'h0) begin
      miscompares++;
      $display("FAIL idle_outputs: got rd_addr=%h wr_addr=%h wr_data=%h want 100/0/0",
               ram_rd_addr, ram_wr_addr, ram_wr_data);
    end
    next_cycle();
  endtask

  task automatic test_simultaneous();
    dbg_req = 1; dbg_we = 1; dbg_addr = 30'h10; dbg_wdata = 32'hDEADBEEF;
    lsu_req = 1; lsu_we = 0; lsu_addr = 30'h20;
    fetch_req = 1; fetch_addr = 30'h30;
    @(negedge clk);
    vectors++;
    if (st1() !== 8'b0010_0001 || ram_wr_addr !== 30'h10 || ram_wr_data !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL simul_dbg_write: got st=%b wa=%h wd=%h want st=00100001 wa=10 wd=deadbeef",
               st1(), ram_wr_addr, ram_wr_data);
    end
    next_cycle(); dbg_req = 0; dbg_we = 0;
    @(negedge clk);
    vectors++;
    if (st1() !== 8'b0100_0010 || ram_rd_addr !== 30'h20) begin
      miscompares++;
      $display("FAIL simul_lsu_grant: got st=%b ra=%h want st=01000010 ra=20", st1(), ram_rd_addr);
    end
    next_cycle(); lsu_req = 0;
    @(negedge clk);
    vectors++;
    if (st1() !== 8'b1000_1010 || rdata !== 32'hC0DE0020 || ram_rd_addr !== 30'h30) begin
      miscompares++;
      $display("FAIL simul_fetch_lsu_rvalid: got st=%b rdata=%h ra=%h want st=10001010 rdata=c0de0020 ra=30",
               st1(), rdata, ram_rd_addr);
    end
    next_cycle(); fetch_req = 0;
    @(negedge clk);
    vectors++;
    if (st1() !== 8'b0001_0000 || rdata !== 32'hC0DE0030) begin
      miscompares++;
      $display("FAIL simul_fetch_rvalid: got st=%b rdata=%h want st=00010000 rdata=c0de0030", st1(), rdata);
    end
    next_cycle(); next_cycle();
  endtask

  task automatic test_starvation();
    lsu_req = 1; lsu_we = 0; lsu_addr = 30'h40;
    fetch_req = 1; fetch_addr = 30'h50;
    for (int c = 0; c < 10; c++) begin
      logic [1:0] want;
      @(negedge clk);
      want = (c == 8) ? 2'b10 : 2'b01;
      vectors++;
      if ({fetch_gnt, lsu_gnt} !== want) begin
        miscompares++;
        $display("FAIL starve_cycle%0d: got fetch/lsu gnt=%b want %b", c, {fetch_gnt, lsu_gnt}, want);
      end
      next_cycle();
    end
    clear_reqs();
    next_cycle(); next_cycle(); next_cycle();
  endtask

  task automatic test_back_to_back();
    lsu_req = 1; lsu_we = 0; lsu_addr = 30'h4;
    fetch_req = 1; fetch_addr = 30'h8;
    @(negedge clk);
    vectors++;
    if ({fetch_gnt2, lsu_gnt2} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_grant0: got fetch/lsu gnt=%b want 01", {fetch_gnt2, lsu_gnt2});
    end
    next_cycle(); lsu_req = 0;
    @(negedge clk);
    vectors++;
    if ({fetch_gnt2, lsu_gnt2} !== 2'b10) begin
      miscompares++;
      $display("FAIL b2b_grant1: got fetch/lsu gnt=%b want 10", {fetch_gnt2, lsu_gnt2});
    end
    next_cycle(); fetch_req = 0; lsu_req = 1; lsu_addr = 30'hC;
    @(negedge clk);
    vectors++;
    if ({lsu_gnt2, fetch_rvalid2, lsu_rvalid2, dbg_rvalid2} !== 4'b1010 || rdata2 !== 32'hC0DE0004) begin
      miscompares++;
      $display("FAIL b2b_rvalid0: got gnt/rv=%b rdata=%h want 1010 rdata=c0de0004",
               {lsu_gnt2, fetch_rvalid2, lsu_rvalid2, dbg_rvalid2}, rdata2);
    end
    next_cycle(); lsu_req = 0;
    @(negedge clk);
    vectors++;
    if ({fetch_rvalid2, lsu_rvalid2, dbg_rvalid2} !== 3'b100 || rdata2 !== 32'hC0DE0008) begin
      miscompares++;
      $display("FAIL b2b_rvalid1: got rv=%b rdata=%h want 100 rdata=c0de0008",
               {fetch_rvalid2, lsu_rvalid2, dbg_rvalid2}, rdata2);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({fetch_rvalid2, lsu_rvalid2, dbg_rvalid2} !== 3'b010 || rdata2 !== 32'hC0DE000C) begin
      miscompares++;
      $display("FAIL b2b_rvalid2: got rv=%b rdata=%h want 010 rdata=c0de000c",
               {fetch_rvalid2, lsu_rvalid2, dbg_rvalid2}, rdata2);
    end
    next_cycle(); next_cycle();
  endtask

  task automatic test_reset_mid();
    fetch_req = 1; fetch_addr = 30'h60;
    @(negedge clk);
    vectors++;
    if (fetch_gnt !== 1'b1 || fetch_gnt2 !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_grant: got %b/%b want 1/1", fetch_gnt, fetch_gnt2);
    end
    next_cycle(); fetch_req = 0; rst = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if (st1() !== 8'h00 || st2() !== 8'h00) begin
        miscompares++;
        $display("FAIL midrst_quiet%0d: got %b/%b want 00000000", c, st1(), st2());
      end
      next_cycle(); rst = 0;
    end
  endtask

  task automatic test_dbg_hold();
    dbg_req = 1; dbg_we = 0; dbg_addr = 30'h70;
    fetch_req = 1; fetch_addr = 30'h80;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vectors++;
      if ({dbg_gnt, fetch_gnt} !== 2'b10) begin
        miscompares++;
        $display("FAIL dbg_hold%0d: got dbg/fetch gnt=%b want 10", c, {dbg_gnt, fetch_gnt});
      end
      next_cycle();
    end
    dbg_req = 0;
    @(negedge clk);
    vectors++;
    if ({dbg_gnt, fetch_gnt} !== 2'b01 || ram_rd_addr !== 30'h80) begin
      miscompares++;
      $display("FAIL dbg_release: got dbg/fetch gnt=%b ra=%h want 01 ra=80", {dbg_gnt, fetch_gnt}, ram_rd_addr);
    end
    next_cycle(); clear_reqs();
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1;
    clear_reqs();
    test_reset();
    test_fetch_read();
    test_simultaneous();
    test_starvation();
    test_back_to_back();
    test_reset_mid();
    test_dbg_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
